// File: rtl/nco_pkg.sv
// Shared constants and helpers for the multi-carrier NCO and its quarter-wave ROM.
package nco_pkg;

    // Quadrant encoding taken from the top two bits of the truncated phase
    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;

    // Peak ROM magnitude; one code short of full scale so negation never overflows
    function automatic int ncoAmplitude(input int outW);
        return (1 << (outW - 1)) - 1;
    endfunction

    // Quadrants 1 and 3 walk the quarter wave backwards
    function automatic int ncoMirrorAddr(input int idx, input logic [1:0] quad, input int lutAw);
        if (quad == QUAD_1 || quad == QUAD_3) begin
            return (1 << lutAw) - 1 - idx;
        end
        return idx;
    endfunction

    // Quarter-wave table entry j, sampled at the half-LSB point so no entry is zero
    function automatic int ncoRomValue(input int j, input int lutAw, input int amp);
        real x;
        real term;
        real sum;
        x    = 2.0 * 3.14159265358979323846 * (real'(j) + 0.5) / real'(1 << (lutAw + 2));
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return $rtoi(real'(amp) * sum + 0.5);
    endfunction

endpackage

// File: rtl/nco_qwave_rom.sv
// Dual-port synchronous-read quarter-wave sine ROM; one port for sine, one for cosine.
// Contents are computed at elaboration from the same formula the table generator uses.
module nco_qwave_rom
    import nco_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LUT_AW-1:0] i_addrA,
    input  logic [LUT_AW-1:0] i_addrB,
    output logic [OUT_W-2:0]  o_dataA,
    output logic [OUT_W-2:0]  o_dataB
);

    localparam int DEPTH = 1 << LUT_AW;
    localparam int AMP   = ncoAmplitude(OUT_W);

    logic [OUT_W-2:0] w_table [DEPTH];

    for (genvar j = 0; j < DEPTH; j++) begin : g_entry
        localparam int VALUE = ncoRomValue(j, LUT_AW, AMP);
        assign w_table[j] = VALUE[OUT_W-2:0];
    end

    // Registered read on both ports; cleared on reset so no stale magnitude survives
    always_ff @(posedge clk) begin
        if (reset) begin
            o_dataA <= '0;
            o_dataB <= '0;
        end else begin
            o_dataA <= w_table[i_addrA];
            o_dataB <= w_table[i_addrB];
        end
    end

endmodule

// File: rtl/nco_multi.sv
// Parametrised NCO: phase accumulator with retunable increment, phase offset,
// quarter-wave ROM lookup and signed sine/cosine outputs through a 3-stage pipeline.
module nco_multi
    import nco_pkg::*;
#(
    parameter int ACC_W          = 24,
    parameter int LUT_AW         = 8,
    parameter int OUT_W          = 12,
    parameter int UPDATE_AT_WRAP = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    sync_clr,
    input  logic                    inc_load,
    input  logic [ACC_W-1:0]        phase_inc,
    input  logic [LUT_AW+1:0]       phase_off,
    output logic signed [OUT_W-1:0] sine_out,
    output logic signed [OUT_W-1:0] cosine_out,
    output logic                    out_valid,
    output logic                    wrap
);

    localparam int PW = LUT_AW + 2;
    localparam logic [PW-1:0] QUARTER_TURN = {2'b01, {LUT_AW{1'b0}}};

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_activeInc;
    logic [ACC_W-1:0] r_pendingInc;
    logic             r_pendingFlag;
    logic             r_wrapPend;

    logic             r_s1Valid;
    logic             r_s1Wrap;
    logic [PW-1:0]    r_s1SinPhase;
    logic [PW-1:0]    r_s1CosPhase;

    logic             r_s2Valid;
    logic             r_s2Wrap;
    logic             r_s2SinNeg;
    logic             r_s2CosNeg;

    logic [ACC_W:0]          w_sum;
    logic                    w_carry;
    logic                    w_transfer;
    logic [PW-1:0]           w_sinPhase;
    logic [PW-1:0]           w_cosPhase;
    logic [LUT_AW-1:0]       w_sinAddr;
    logic [LUT_AW-1:0]       w_cosAddr;
    logic [OUT_W-2:0]        w_sinMag;
    logic [OUT_W-2:0]        w_cosMag;
    logic signed [OUT_W-1:0] w_sinExt;
    logic signed [OUT_W-1:0] w_cosExt;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_activeInc};
    assign w_carry = en & ~sync_clr & w_sum[ACC_W];

    // With a zero active increment the accumulator can never carry, so a pending
    // word is taken straight away even in wrap-aligned mode; otherwise it would stall forever.
    assign w_transfer = r_pendingFlag &
                        ((UPDATE_AT_WRAP == 0) || (r_activeInc == '0) || w_carry);

    // Pending/active increment pair: a load arriving with a transfer stays pending
    always_ff @(posedge clk) begin
        if (reset) begin
            r_activeInc   <= '0;
            r_pendingInc  <= '0;
            r_pendingFlag <= 1'b0;
        end else begin
            if (w_transfer) begin
                r_activeInc   <= r_pendingInc;
                r_pendingFlag <= 1'b0;
            end
            if (inc_load) begin
                r_pendingInc  <= phase_inc;
                r_pendingFlag <= 1'b1;
            end
        end
    end

    // Phase accumulator; the carry is remembered for the sample that will use the new value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_wrapPend <= 1'b0;
        end else if (sync_clr) begin
            r_acc      <= '0;
            r_wrapPend <= 1'b0;
        end else if (en) begin
            r_acc      <= w_sum[ACC_W-1:0];
            r_wrapPend <= w_sum[ACC_W];
        end
    end

    assign w_sinPhase = r_acc[ACC_W-1 -: PW] + phase_off;
    assign w_cosPhase = w_sinPhase + QUARTER_TURN;

    // Stage 1: capture truncated, offset sine and cosine phases of the current accumulator
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1Valid    <= 1'b0;
            r_s1Wrap     <= 1'b0;
            r_s1SinPhase <= '0;
            r_s1CosPhase <= '0;
        end else begin
            r_s1Valid    <= en;
            r_s1Wrap     <= r_wrapPend;
            r_s1SinPhase <= w_sinPhase;
            r_s1CosPhase <= w_cosPhase;
        end
    end

    assign w_sinAddr = LUT_AW'(ncoMirrorAddr(int'(r_s1SinPhase[LUT_AW-1:0]),
                                             r_s1SinPhase[PW-1 -: 2], LUT_AW));
    assign w_cosAddr = LUT_AW'(ncoMirrorAddr(int'(r_s1CosPhase[LUT_AW-1:0]),
                                             r_s1CosPhase[PW-1 -: 2], LUT_AW));

    nco_qwave_rom #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_rom (
        .clk     (clk),
        .reset   (reset),
        .i_addrA (w_sinAddr),
        .i_addrB (w_cosAddr),
        .o_dataA (w_sinMag),
        .o_dataB (w_cosMag)
    );

    // Stage 2: carry the sign decisions alongside the ROM read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2Valid  <= 1'b0;
            r_s2Wrap   <= 1'b0;
            r_s2SinNeg <= 1'b0;
            r_s2CosNeg <= 1'b0;
        end else begin
            r_s2Valid  <= r_s1Valid;
            r_s2Wrap   <= r_s1Wrap;
            r_s2SinNeg <= (r_s1SinPhase[PW-1 -: 2] == QUAD_2) || (r_s1SinPhase[PW-1 -: 2] == QUAD_3);
            r_s2CosNeg <= (r_s1CosPhase[PW-1 -: 2] == QUAD_2) || (r_s1CosPhase[PW-1 -: 2] == QUAD_3);
        end
    end

    assign w_sinExt = signed'({1'b0, w_sinMag});
    assign w_cosExt = signed'({1'b0, w_cosMag});

    // Stage 3: apply sign in the lower half-cycle; samples hold while nothing valid arrives
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            wrap       <= 1'b0;
            sine_out   <= '0;
            cosine_out <= '0;
        end else begin
            out_valid <= r_s2Valid;
            wrap      <= r_s2Valid & r_s2Wrap;
            if (r_s2Valid) begin
                sine_out   <= r_s2SinNeg ? -w_sinExt : w_sinExt;
                cosine_out <= r_s2CosNeg ? -w_cosExt : w_cosExt;
            end
        end
    end

endmodule

// File: tb/tb_nco_multi.sv
// Directed bench for nco_multi: one immediate-retune instance and one wrap-aligned instance.
module tb_nco_multi;

    localparam int ACC_W       = 24;
    localparam int LUT_AW      = 8;
    localparam int OUT_W       = 12;
    localparam int MAX_SAMPLES = 1100;

    logic clk = 1'b0;
    logic reset;

    logic                    en, syncClr, incLoad;
    logic [ACC_W-1:0]        phaseInc;
    logic [LUT_AW+1:0]       phaseOff;
    logic signed [OUT_W-1:0] sineOut, cosineOut;
    logic                    outValid, wrapOut;

    logic                    en1, syncClr1, incLoad1;
    logic [ACC_W-1:0]        phaseInc1;
    logic [LUT_AW+1:0]       phaseOff1;
    logic signed [OUT_W-1:0] sineOut1, cosineOut1;
    logic                    outValid1, wrapOut1;

    int checks   = 0;
    int failures = 0;

    int gotSine [MAX_SAMPLES];
    int gotCos  [MAX_SAMPLES];
    int gotWrap [MAX_SAMPLES];
    int gotCount;
    int firstValidTick;

    int sineQ [4] = '{6, 2047, -6, -2047};
    int cosQ  [4] = '{2047, -6, -2047, 6};

    nco_multi #(
        .ACC_W          (ACC_W),
        .LUT_AW         (LUT_AW),
        .OUT_W          (OUT_W),
        .UPDATE_AT_WRAP (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .sync_clr   (syncClr),
        .inc_load   (incLoad),
        .phase_inc  (phaseInc),
        .phase_off  (phaseOff),
        .sine_out   (sineOut),
        .cosine_out (cosineOut),
        .out_valid  (outValid),
        .wrap       (wrapOut)
    );

    nco_multi #(
        .ACC_W          (ACC_W),
        .LUT_AW         (LUT_AW),
        .OUT_W          (OUT_W),
        .UPDATE_AT_WRAP (1)
    ) dutWrap (
        .clk        (clk),
        .reset      (reset),
        .en         (en1),
        .sync_clr   (syncClr1),
        .inc_load   (incLoad1),
        .phase_inc  (phaseInc1),
        .phase_off  (phaseOff1),
        .sine_out   (sineOut1),
        .cosine_out (cosineOut1),
        .out_valid  (outValid1),
        .wrap       (wrapOut1)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive en for nEn cycles (optional sync_clr / inc_load on given cycles), then drain
    task automatic applyStimulus(input int nEn, input int clrAt, input int loadAt,
                                 input logic [ACC_W-1:0] loadVal, input bit alt);
        gotCount       = 0;
        firstValidTick = -1;
        for (int t = 0; t < nEn + 3; t++) begin
            if (!alt) begin
                en      = (t < nEn);
                syncClr = (t == clrAt);
                incLoad = (t == loadAt);
                if (t == loadAt) phaseInc = loadVal;
            end else begin
                en1      = (t < nEn);
                syncClr1 = (t == clrAt);
                incLoad1 = (t == loadAt);
                if (t == loadAt) phaseInc1 = loadVal;
            end
            tick();
            if ((alt ? outValid1 : outValid) && gotCount < MAX_SAMPLES) begin
                if (firstValidTick < 0) firstValidTick = t;
                gotSine[gotCount] = alt ? sineOut1 : sineOut;
                gotCos[gotCount]  = alt ? cosineOut1 : cosineOut;
                gotWrap[gotCount] = alt ? int'(wrapOut1) : int'(wrapOut);
                gotCount++;
            end
        end
        en = 1'b0; syncClr = 1'b0; incLoad = 1'b0;
        en1 = 1'b0; syncClr1 = 1'b0; incLoad1 = 1'b0;
    endtask

    initial begin
        int expSine [10];
        int expCos  [6];
        int expWrap [10];
        int wrapTotal;

        reset = 1'b1;
        en = 1'b0; syncClr = 1'b0; incLoad = 1'b0; phaseInc = '0; phaseOff = '0;
        en1 = 1'b0; syncClr1 = 1'b0; incLoad1 = 1'b0; phaseInc1 = '0; phaseOff1 = '0;
        tick();
        tick();
        checkOutput("reset_valid", int'(outValid), 0);
        checkOutput("reset_sine", sineOut, 0);
        checkOutput("reset_cos", cosineOut, 0);
        checkOutput("reset_wrap", int'(wrapOut), 0);
        reset = 1'b0;

        // Quarter-turn increment: four samples per period
        incLoad = 1'b1; phaseInc = 24'h400000;
        tick();
        incLoad = 1'b0;
        tick();
        applyStimulus(12, -1, -1, '0, 1'b0);
        checkOutput("basic_latency", firstValidTick, 2);
        checkOutput("basic_count", gotCount, 12);
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("basic_sine%0d", k), gotSine[k], sineQ[k % 4]);
            checkOutput($sformatf("basic_cos%0d", k), gotCos[k], cosQ[k % 4]);
            checkOutput($sformatf("basic_wrap%0d", k), gotWrap[k], (k > 0 && k % 4 == 0) ? 1 : 0);
        end

        // en low: valid drops, last sample held
        checkOutput("hold_valid", int'(outValid), 0);
        checkOutput("hold_sine", sineOut, -2047);
        repeat (5) tick();
        checkOutput("hold5_valid", int'(outValid), 0);
        checkOutput("hold5_sine", sineOut, -2047);
        checkOutput("hold5_cos", cosineOut, 6);

        // sync_clr on the cycle that would otherwise carry
        applyStimulus(6, 3, -1, '0, 1'b0);
        expSine = '{6, 2047, -6, -2047, 6, 2047, 0, 0, 0, 0};
        expCos  = '{2047, -6, -2047, 6, 2047, -6};
        expWrap = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        checkOutput("clr_count", gotCount, 6);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("clr_sine%0d", k), gotSine[k], expSine[k]);
            checkOutput($sformatf("clr_cos%0d", k), gotCos[k], expCos[k]);
            checkOutput($sformatf("clr_wrap%0d", k), gotWrap[k], expWrap[k]);
        end

        // Quarter-turn offset: sine follows the unoffset cosine
        phaseOff = 10'd256;
        applyStimulus(4, -1, -1, '0, 1'b0);
        expSine = '{-2047, 6, 2047, -6, 0, 0, 0, 0, 0, 0};
        expCos  = '{6, 2047, -6, -2047, 0, 0};
        expWrap = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("off_sine%0d", k), gotSine[k], expSine[k]);
            checkOutput($sformatf("off_cos%0d", k), gotCos[k], expCos[k]);
            checkOutput($sformatf("off_wrap%0d", k), gotWrap[k], expWrap[k]);
        end
        phaseOff = '0;

        // Slow tone: one LUT step per sample, 1024-sample period
        incLoad = 1'b1; phaseInc = 24'h004000;
        tick();
        incLoad = 1'b0; syncClr = 1'b1;
        tick();
        syncClr = 1'b0;
        applyStimulus(1030, -1, -1, '0, 1'b0);
        checkOutput("slow_count", gotCount, 1030);
        checkOutput("slow_sine0", gotSine[0], 6);
        checkOutput("slow_sine1", gotSine[1], 19);
        checkOutput("slow_sine256", gotSine[256], 2047);
        checkOutput("slow_sine512", gotSine[512], -6);
        checkOutput("slow_sine768", gotSine[768], -2047);
        checkOutput("slow_cos0", gotCos[0], 2047);
        checkOutput("slow_wrap1024", gotWrap[1024], 1);
        wrapTotal = 0;
        for (int k = 0; k < gotCount; k++) wrapTotal += gotWrap[k];
        checkOutput("slow_wrap_total", wrapTotal, 1);

        // Reset while streaming: pipeline flushed, increment cleared
        en = 1'b1;
        repeat (5) tick();
        checkOutput("prereset_valid", int'(outValid), 1);
        reset = 1'b1;
        tick();
        checkOutput("midreset_valid", int'(outValid), 0);
        checkOutput("midreset_sine", sineOut, 0);
        checkOutput("midreset_cos", cosineOut, 0);
        reset = 1'b0;
        applyStimulus(4, -1, -1, '0, 1'b0);
        checkOutput("postreset_latency", firstValidTick, 2);
        checkOutput("postreset_count", gotCount, 4);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("postreset_sine%0d", k), gotSine[k], 6);
            checkOutput($sformatf("postreset_cos%0d", k), gotCos[k], 2047);
        end

        // Wrap-aligned retune: half-turn word loaded mid-period takes effect at the wrap
        incLoad1 = 1'b1; phaseInc1 = 24'h400000;
        tick();
        incLoad1 = 1'b0;
        tick();
        applyStimulus(10, -1, 1, 24'h800000, 1'b1);
        expSine = '{6, 2047, -6, -2047, 6, -6, 6, -6, 6, -6};
        expWrap = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0};
        checkOutput("atwrap_count", gotCount, 10);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("atwrap_sine%0d", k), gotSine[k], expSine[k]);
            checkOutput($sformatf("atwrap_wrap%0d", k), gotWrap[k], expWrap[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
